// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch buffer between PC generation and decode
// Optional FETCHQ_BYPASS_EN: forward a response straight to decode when the queue head is waiting on it.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_pc,
  input  logic                     fetch_pred_taken,
  output logic                     fetch_ready,
  output logic                     imem_req_valid,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_resp_valid,
  input  logic [31:0]              imem_resp_data,
  output logic                     dec_valid,
  output logic [31:0]              dec_pc,
  output logic [31:0]              dec_instr,
  output logic                     dec_pred_taken,
  input  logic                     dec_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   head_q, head_d, resp_q, resp_d, tail_q, tail_d, drop_q, drop_d;
  logic [31:0]   pc_mem    [DEPTH];
  logic          pt_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [AW:0]   used, outstanding;
  logic [AW+1:0] credit_sum;
  logic          credit_ok, req_fire, deq_fire, buffered;
  logic          resp_slot_ok, resp_advance, resp_write, resp_drop;
  logic          bypass, bypass_take;

  assign used        = tail_q - head_q;
  assign outstanding = tail_q - resp_q;
  assign occupancy   = used;

  // Stale in-flight responses still occupy memory-side capacity, so they count against credit.
  assign credit_sum = {1'b0, used} + {1'b0, drop_q};
  assign credit_ok  = credit_sum < (AW+2)'(DEPTH);

  assign fetch_ready    = rst_n & imem_req_ready & credit_ok & ~flush;
  assign imem_req_valid = rst_n & fetch_valid & credit_ok & ~flush;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign resp_slot_ok = (drop_q == '0) & (resp_q != tail_q);
  assign resp_advance = imem_resp_valid & resp_slot_ok & ~flush;
  assign resp_drop    = imem_resp_valid & (drop_q != '0);
  assign buffered     = (head_q != resp_q);

`ifdef FETCHQ_BYPASS_EN
  assign bypass = imem_resp_valid & ~flush & (drop_q == '0) & (head_q == resp_q) & (resp_q != tail_q);
`else
  assign bypass = 1'b0;
`endif
  assign bypass_take = bypass & dec_ready;
  assign resp_write  = resp_advance & ~bypass_take;

  assign dec_valid      = (buffered & ~flush) | bypass;
  assign dec_pc         = pc_mem[head_q[AW-1:0]];
  assign dec_pred_taken = pt_mem[head_q[AW-1:0]];
  assign dec_instr      = bypass ? imem_resp_data : instr_mem[head_q[AW-1:0]];
  assign deq_fire       = dec_valid & dec_ready;

  always_comb begin
    head_d = head_q;
    resp_d = resp_q;
    tail_d = tail_q;
    drop_d = drop_q;
    if (flush) begin
      // A response landing in the flush cycle is one of the discarded ones.
      head_d = tail_q;
      resp_d = tail_q;
      drop_d = drop_q + outstanding
             - {{AW{1'b0}}, imem_resp_valid & ((drop_q != '0) | (outstanding != '0))};
    end else begin
      if (req_fire)     tail_d = tail_q + 1'b1;
      if (deq_fire)     head_d = head_q + 1'b1;
      if (resp_advance) resp_d = resp_q + 1'b1;
      if (resp_drop)    drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      resp_q <= '0;
      tail_q <= '0;
      drop_q <= '0;
    end else begin
      head_q <= head_d;
      resp_q <= resp_d;
      tail_q <= tail_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      pc_mem[tail_q[AW-1:0]] <= fetch_pc;
      pt_mem[tail_q[AW-1:0]] <= fetch_pred_taken;
    end
    if (resp_write) instr_mem[resp_q[AW-1:0]] <= imem_resp_data;
  end

  // A response with nothing outstanding and nothing to drop is a memory-side protocol error.
  resp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> ((drop_q != '0) || (resp_q != tail_q)));

endmodule
